fp_sequencer: RTL

- Control unit for the floating_point add/multiply datapath.
- Accepts a start/operation request and drives every datapath select, enable and shift-amount input in sequence.
- Consumes the datapath status returns: smallAluResult, endMultiplication, rounderOverflow and the leading-one distances.
- Holds busy for the whole operation, then pulses done once the final result register has been loaded.

---
 rtl/fp_sequencer_if.sv | 60 ++++++
 rtl/fp_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sequencer_if.sv
// fp_sequencer_if: request, datapath control and status bundle for the
// floating-point add/multiply sequencer.
//   master : the sequencer (drives controls, receives request and status)
//   slave  : requester/datapath side
interface fp_sequencer_if;
    logic        start;
    logic        op_mul;
    logic        op_sub;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  smallAluResult;
    logic        endMultiplication;
    logic        rounderOverflow;
    logic [63:0] posFirst28posReferential;

    logic        loadRegSmall;
    logic        muxAControlSmall;
    logic        muxBControlSmall;
    logic [3:0]  smallALUOperation;
    logic        controlToMux01;
    logic        controlToMux02;
    logic        controlToMux03;
    logic        controlToMux04;
    logic        controlToMux05;
    logic [7:0]  controlShiftRight;
    logic        isSum;
    logic        sum_sub;
    logic        bigALUReset;
    logic        muxDataRegValor2;
    logic        rightOrLeft;
    logic [22:0] howMany;
    logic        IncreaseOrDecreaseEnable;
    logic [3:0]  controlToIncreaseOrDecrease;
    logic [7:0]  howManyToIncreaseOrDecrease;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, op_mul, op_sub, sign_a, sign_b, smallAluResult,
               endMultiplication, rounderOverflow, posFirst28posReferential,
        output loadRegSmall, muxAControlSmall, muxBControlSmall, smallALUOperation,
               controlToMux01, controlToMux02, controlToMux03, controlToMux04,
               controlToMux05, controlShiftRight, isSum, sum_sub, bigALUReset,
               muxDataRegValor2, rightOrLeft, howMany, IncreaseOrDecreaseEnable,
               controlToIncreaseOrDecrease, howManyToIncreaseOrDecrease,
               busy, done, error
    );

    modport slave (
        output start, op_mul, op_sub, sign_a, sign_b, smallAluResult,
               endMultiplication, rounderOverflow, posFirst28posReferential,
        input  loadRegSmall, muxAControlSmall, muxBControlSmall, smallALUOperation,
               controlToMux01, controlToMux02, controlToMux03, controlToMux04,
               controlToMux05, controlShiftRight, isSum, sum_sub, bigALUReset,
               muxDataRegValor2, rightOrLeft, howMany, IncreaseOrDecreaseEnable,
               controlToIncreaseOrDecrease, howManyToIncreaseOrDecrease,
               busy, done, error
    );
endinterface

// File: rtl/fp_sequencer.sv
// fp_sequencer: Moore control FSM for the floating-point add/multiply datapath.
// All outputs are registered alongside the state, so they always reflect the
// current state. Optional macro FP_SEQ_MUL_TIMEOUT_EN bounds MUL_WAIT to
// MUL_TIMEOUT cycles and flags error on expiry.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for start, request latched on start
//   LOAD     | operand registers settle
//   EXP_DIFF | SmallAlu computes exponent difference A-B
//   ALIGN    | select larger exponent path, right-shift smaller mantissa
//   ADD      | BigALU add/subtract of magnitudes
//   MUL_EXP  | SmallAlu computes A+B-127, BigALU cleared
//   MUL_WAIT | waiting for endMultiplication
//   NORM     | normalise by leading-one distance
//   ROUND    | wait for rounder, decide on renormalisation
//   RENORM   | one-bit right shift of the rounder result
//   WRITE    | result register captures
//   DONE     | one-cycle done pulse
module fp_sequencer (
    input  logic           clk,
    input  logic           reset,
    fp_sequencer_if.master bus
);
    localparam logic [3:0] SMALL_OP_SUB     = 4'd1;
    localparam logic [3:0] SMALL_OP_ADDBIAS = 4'd2;
    localparam logic [3:0] INCDEC_INC       = 4'd0;
    localparam logic [3:0] INCDEC_DEC       = 4'd1;
    localparam int         MAX_SHIFT        = 28;
    localparam int         RENORM_MAX       = 2;
`ifdef FP_SEQ_MUL_TIMEOUT_EN
    localparam int         MUL_TIMEOUT      = 64;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_EXP_DIFF, S_ALIGN, S_ADD, S_MUL_EXP, S_MUL_WAIT,
        S_NORM, S_ROUND, S_RENORM, S_WRITE, S_DONE
    } state_t;

    typedef struct packed {
        logic        load_reg_small;
        logic        mux_a_small;
        logic        mux_b_small;
        logic [3:0]  small_alu_op;
        logic        mux01;
        logic        mux02;
        logic        mux03;
        logic        mux04;
        logic        mux05;
        logic [7:0]  shift_right;
        logic        is_sum;
        logic        sum_sub;
        logic        big_alu_reset;
        logic        mux_data_reg_valor2;
        logic        right_or_left;
        logic [22:0] how_many;
        logic        incdec_en;
        logic [3:0]  incdec_op;
        logic [7:0]  incdec_amt;
        logic        busy;
        logic        done;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       error_q, error_d;
    logic       op_mul_q, op_mul_d;
    logic       op_sub_q, op_sub_d;
    logic       sign_a_q, sign_a_d;
    logic       sign_b_q, sign_b_d;
    logic [1:0] passes_q, passes_d;
`ifdef FP_SEQ_MUL_TIMEOUT_EN
    logic [6:0] mul_cnt_q, mul_cnt_d;
`endif

    // Magnitudes of the signed exponent difference and leading-one distance;
    // 9 bits so that -128 maps to +128 without wrapping.
    logic [7:0] k_val;
    logic [8:0] d_mag;
    logic [8:0] k_mag;
    logic       unused_pos_hi;

    assign k_val         = bus.posFirst28posReferential[7:0];
    assign d_mag         = bus.smallAluResult[7] ? (9'd0 - {1'b1, bus.smallAluResult})
                                                 : {1'b0, bus.smallAluResult};
    assign k_mag         = k_val[7] ? (9'd0 - {1'b1, k_val}) : {1'b0, k_val};
    assign unused_pos_hi = ^bus.posFirst28posReferential[63:8];

    // Next-state, request latch, pass counter and next-output decode.
    always_comb begin
        state_d  = state_q;
        error_d  = error_q;
        op_mul_d = op_mul_q;
        op_sub_d = op_sub_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        passes_d = passes_q;
`ifdef FP_SEQ_MUL_TIMEOUT_EN
        mul_cnt_d = mul_cnt_q;
`endif
        ctrl_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_mul_d = bus.op_mul;
                    op_sub_d = bus.op_sub;
                    sign_a_d = bus.sign_a;
                    sign_b_d = bus.sign_b;
                    error_d  = 1'b0;
                    passes_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD:     state_d = op_mul_q ? S_MUL_EXP : S_EXP_DIFF;
            S_EXP_DIFF: state_d = S_ALIGN;
            S_ALIGN:    state_d = S_ADD;
            S_ADD:      state_d = S_NORM;
            S_MUL_EXP: begin
`ifdef FP_SEQ_MUL_TIMEOUT_EN
                mul_cnt_d = '0;
`endif
                state_d = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (bus.endMultiplication) begin
`ifdef FP_SEQ_MUL_TIMEOUT_EN
                    mul_cnt_d = '0;
`endif
                    state_d = S_NORM;
                end
`ifdef FP_SEQ_MUL_TIMEOUT_EN
                else if (mul_cnt_q == 7'(MUL_TIMEOUT - 1)) begin
                    // Result register is never loaded on timeout.
                    mul_cnt_d = '0;
                    error_d   = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    mul_cnt_d = mul_cnt_q + 7'd1;
                end
`endif
            end
            S_NORM:     state_d = S_ROUND;
            S_ROUND: begin
                if (!bus.rounderOverflow) begin
                    state_d = S_WRITE;
                end else if (passes_q < 2'(RENORM_MAX)) begin
                    passes_d = passes_q + 2'd1;
                    state_d  = S_RENORM;
                end else begin
                    error_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_RENORM:   state_d = S_ROUND;
            S_WRITE:    state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        case (state_d)
            S_EXP_DIFF: begin
                ctrl_d.small_alu_op   = SMALL_OP_SUB;
                ctrl_d.load_reg_small = 1'b1;
            end
            S_ALIGN: begin
                ctrl_d.mux01       = ~bus.smallAluResult[7];
                ctrl_d.mux03       = ~bus.smallAluResult[7];
                ctrl_d.mux04       = bus.smallAluResult[7];
                ctrl_d.shift_right = (d_mag > 9'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : d_mag[7:0];
            end
            S_ADD: begin
                ctrl_d.is_sum  = 1'b1;
                ctrl_d.sum_sub = sign_a_q ^ sign_b_q ^ op_sub_q;
            end
            S_MUL_EXP: begin
                ctrl_d.small_alu_op        = SMALL_OP_ADDBIAS;
                ctrl_d.load_reg_small      = 1'b1;
                ctrl_d.big_alu_reset       = 1'b1;
                ctrl_d.mux_data_reg_valor2 = 1'b1;
            end
            S_NORM: begin
                if (k_val != 8'd0) begin
                    ctrl_d.incdec_en     = 1'b1;
                    ctrl_d.right_or_left = k_val[7];
                    ctrl_d.incdec_op     = k_val[7] ? INCDEC_DEC : INCDEC_INC;
                    ctrl_d.how_many      = {14'd0, k_mag};
                    ctrl_d.incdec_amt    = k_mag[7:0];
                end
            end
            S_RENORM: begin
                ctrl_d.mux05      = 1'b1;
                ctrl_d.mux02      = 1'b1;
                ctrl_d.how_many   = 23'd1;
                ctrl_d.incdec_en  = 1'b1;
                ctrl_d.incdec_op  = INCDEC_INC;
                ctrl_d.incdec_amt = 8'd1;
            end
            S_DONE:  ctrl_d.done = 1'b1;
            default: ;
        endcase

        ctrl_d.busy = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State, latched request and registered outputs; reset aborts at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            error_q  <= 1'b0;
            op_mul_q <= 1'b0;
            op_sub_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            passes_q <= '0;
`ifdef FP_SEQ_MUL_TIMEOUT_EN
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            error_q  <= error_d;
            op_mul_q <= op_mul_d;
            op_sub_q <= op_sub_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            passes_q <= passes_d;
`ifdef FP_SEQ_MUL_TIMEOUT_EN
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    assign bus.loadRegSmall                = ctrl_q.load_reg_small;
    assign bus.muxAControlSmall            = ctrl_q.mux_a_small;
    assign bus.muxBControlSmall            = ctrl_q.mux_b_small;
    assign bus.smallALUOperation           = ctrl_q.small_alu_op;
    assign bus.controlToMux01              = ctrl_q.mux01;
    assign bus.controlToMux02              = ctrl_q.mux02;
    assign bus.controlToMux03              = ctrl_q.mux03;
    assign bus.controlToMux04              = ctrl_q.mux04;
    assign bus.controlToMux05              = ctrl_q.mux05;
    assign bus.controlShiftRight           = ctrl_q.shift_right;
    assign bus.isSum                       = ctrl_q.is_sum;
    assign bus.sum_sub                     = ctrl_q.sum_sub;
    assign bus.bigALUReset                 = ctrl_q.big_alu_reset;
    assign bus.muxDataRegValor2            = ctrl_q.mux_data_reg_valor2;
    assign bus.rightOrLeft                 = ctrl_q.right_or_left;
    assign bus.howMany                     = ctrl_q.how_many;
    assign bus.IncreaseOrDecreaseEnable    = ctrl_q.incdec_en;
    assign bus.controlToIncreaseOrDecrease = ctrl_q.incdec_op;
    assign bus.howManyToIncreaseOrDecrease = ctrl_q.incdec_amt;
    assign bus.busy                        = ctrl_q.busy;
    assign bus.done                        = ctrl_q.done;
    assign bus.error                       = error_q;
endmodule
